shift_chain_ctrl: RTL and testbench
===================================

# shift_chain_ctrl

Sequencer for a serial shift-register chain of the kind used in the design-flow test set. Accepts a parallel word over a valid/ready handshake, drives it MSB-first into the chain with a per-bit shift enable, and captures the bits returned by the chain into a parallel result. An inter-word gap and a synchronous abort are provided. The block sits between a parallel producer/consumer and one serial chain.

## Interface
- WIDTH, 12: bits per word and shift cycles per transfer; legal range 2..64.
- GAP, 2: idle cycles inserted after each word before load_ready reasserts; legal range 0..15.
- clk  input  1  rising-edge clock for all state.
- clr  input  1  reset; asynchronous, active-high, clears all state and outputs.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  WIDTH  word to shift out; bit WIDTH-1 is sent first.
- load_ready  output  1  controller accepts a word this cycle.
- abort  input  1  synchronous; cancels the transfer in progress.
- shift_in  input  1  serial bit returned from the chain.
- shift_out  output  1  serial bit driven into the chain.
- shift_en  output  1  chain advances on this clock edge.
- cap_valid  output  1  one-cycle pulse; cap_data holds a new result.
- cap_data  output  WIDTH  word captured from shift_in; first returned bit lands in bit WIDTH-1.
- busy  output  1  high in SHIFT or GAP.

## Operation
- States: IDLE, SHIFT, GAP. Reset state is IDLE.
- Internal state: sreg[WIDTH-1:0], a bit counter cnt of width clog2(WIDTH), and a gap counter gcnt of 4 bits.
- IDLE:
  - load_ready = 1, shift_en = 0.
  - On an edge with load_valid=1: sreg <= load_data, cnt <= 0, next state SHIFT.
- SHIFT:
  - shift_en = 1, shift_out = sreg[WIDTH-1], load_ready = 0.
  - Each edge: sreg <= {sreg[WIDTH-2:0], shift_in}, cnt <= cnt+1.
  - Edge with cnt == WIDTH-1: cap_data <= {sreg[WIDTH-2:0], shift_in}, cap_valid <= 1. Next state is GAP with gcnt <= 0, or IDLE if GAP == 0.
- GAP:
  - shift_en = 0, load_ready = 0.
  - gcnt increments each edge; at gcnt == GAP-1, next state is IDLE.
- abort:
  - Sampled at each edge in SHIFT or GAP. Next state is IDLE.
  - No cap_valid is issued and cap_data is unchanged.
  - abort has priority over transfer completion on the same edge.
  - abort is ignored in IDLE.
- shift_out is 0 whenever the state is not SHIFT.
- load_data is sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset values: load_ready=0 while clr is asserted, then 1 from the first cycle after clr deasserts. shift_en=0, shift_out=0, cap_valid=0, cap_data=0, busy=0.
- Accept edge t:
  - shift_en is high in cycles t+1 .. t+WIDTH.
  - In cycle t+1+k, shift_out carries load_data[WIDTH-1-k].
  - cap_valid is high only in cycle t+WIDTH+1.
  - load_ready is high again in cycle t+WIDTH+GAP+1.
- Throughput: one word per WIDTH+GAP+1 cycles. With GAP=0, cap_valid and load_ready are high in the same cycle.
- cap_valid is always exactly one cycle wide. There is no backpressure on the capture side.
- clr asserted mid-transfer: all outputs clear immediately (asynchronous), the partial word is discarded, and there is no cap_valid.
- Every output is driven from a register or decoded from the registered state. There is no combinational path from load_valid or shift_in to any output.

## Test plan
- Reset and loopback: WIDTH=12, GAP=2, tie shift_in = shift_out, send 12'hA5C.
  - Expect shift_out sequence 1,0,1,0,0,1,0,1,1,1,0,0.
  - Expect cap_valid at cycle t+13 with cap_data=12'hA5C.
  - Expect load_ready back at cycle t+15.
- External chain: a 12-stage shift register clocked when shift_en=1 and preloaded with 12'h3F0; shift in 12'h000.
  - Expect cap_data=12'h3F0 and the chain holding 12'h000.
- Back-to-back, GAP=0: hold load_valid high with 12'hFFF then 12'h001.
  - Second accept occurs at t+13; cap_valid pulses at t+13 and t+26.
- Abort: assert abort in cycle t+6.
  - Expect state IDLE, load_ready=1 in cycle t+7, no cap_valid, cap_data unchanged from the previous word.
- Async reset mid-SHIFT: pulse clr at cycle t+4 without a clock edge.
  - Expect shift_en=0, busy=0 and cap_data=0 immediately.
  - A new word is accepted on the first edge after release.
- Ignored load: toggle load_valid and load_data during SHIFT and GAP.
  - Expect no effect on the serial stream or on cap_data.

Source files
------------

// File: rtl/shift_chain_ctrl.sv
// Serial shift-chain sequencer: loads a parallel word, shifts it out MSB-first
// while capturing the returned bits, then holds off for GAP idle cycles.
module shift_chain_ctrl #(
  parameter int WIDTH = 12,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  input  logic             shift_in,
  output logic             shift_out,
  output logic             shift_en,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output logic             busy
);

  // state   | meaning
  // S_IDLE  | waiting for a word, load_ready high
  // S_SHIFT | one chain bit per cycle, WIDTH cycles
  // S_GAP   | GAP idle cycles before the next word
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [3:0]    GCNT_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             last_bit;

  assign last_bit = (state == S_SHIFT) && (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (load_valid) state_nx = S_SHIFT;
      S_SHIFT: begin
        if (abort)         state_nx = S_IDLE;
        else if (last_bit) state_nx = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (abort || gcnt == GCNT_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      state     <= state_nx;
      cap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            sreg <= load_data;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], shift_in};
          cnt  <= cnt + CW'(1);
          // abort wins over completion: no capture on an aborted final bit
          if (last_bit && !abort) begin
            cap_data  <= {sreg[WIDTH-2:0], shift_in};
            cap_valid <= 1'b1;
            gcnt      <= '0;
          end
        end
        S_GAP: gcnt <= gcnt + 4'd1;
        default: ;
      endcase
    end
  end

  // load_ready is held low for the whole time clr is asserted
  assign load_ready = (state == S_IDLE) && !clr;
  assign shift_en   = (state == S_SHIFT);
  assign shift_out  = shift_en && sreg[WIDTH-1];
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Bench for shift_chain_ctrl: directed and random transfers against a
// cycle-indexed model of the serial stream, capture and handshake timing.
module tb_shift_chain_ctrl;

  localparam int W = 12;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic         abort = 1'b0;
  logic         shift_in, shift_out, shift_en, cap_valid, busy;
  logic [W-1:0] cap_data;

  logic         lv0 = 1'b0;
  logic [W-1:0] ld0 = '0;
  logic         abort0 = 1'b0;
  logic         lr0, so0, se0, cv0, busy0;
  logic [W-1:0] cd0;

  logic         loopback = 1'b1;
  logic         chain_load = 1'b0;
  logic [W-1:0] chain_pre = '0;
  logic [W-1:0] chain = '0;
  logic [W-1:0] exp_cap = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(W), .GAP(G)) u_dut (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .abort(abort), .shift_in(shift_in),
    .shift_out(shift_out), .shift_en(shift_en), .cap_valid(cap_valid),
    .cap_data(cap_data), .busy(busy)
  );

  shift_chain_ctrl #(.WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .clr(clr), .load_valid(lv0), .load_data(ld0),
    .load_ready(lr0), .abort(abort0), .shift_in(so0),
    .shift_out(so0), .shift_en(se0), .cap_valid(cv0),
    .cap_data(cd0), .busy(busy0)
  );

  // external chain: W-stage register that advances only when shift_en is high
  assign shift_in = loopback ? shift_out : chain[W-1];
  always @(posedge clk) begin
    if (chain_load)    chain <= chain_pre;
    else if (shift_en) chain <= {chain[W-2:0], shift_out};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer; cycle c counts from the accept edge (c=1 is the first SHIFT cycle).
  task automatic xfer(input logic [W-1:0] word, input logic [W-1:0] pre,
                      input bit lb, input int abort_at, input bit tog);
    int  last;
    bit  gone;
    last = W + G + 1;
    @(posedge clk); #1;
    loopback   = lb;
    load_valid = 1'b1;
    load_data  = word;
    chain_pre  = pre;
    chain_load = 1'b1;
    @(negedge clk);
    chk("rdy_pre", load_ready, 1);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      chain_load = 1'b0;
      abort = (c == abort_at);
      if (tog && c <= W + G && (abort_at == 0 || c <= abort_at)) begin
        load_valid = 1'($urandom_range(0, 1));
        load_data  = W'($urandom);
      end else begin
        load_valid = 1'b0;
      end
      gone = (abort_at > 0) && (c > abort_at);
      @(negedge clk);
      if (gone) begin
        chk("ab_shift_en", shift_en, 0);
        chk("ab_shift_out", shift_out, 0);
        chk("ab_busy", busy, 0);
        chk("ab_cap_valid", cap_valid, 0);
        chk("ab_load_ready", load_ready, 1);
      end else begin
        chk("shift_en", shift_en, c <= W);
        chk("shift_out", shift_out, (c <= W) ? word[W-c] : 1'b0);
        chk("cap_valid", cap_valid, c == W + 1);
        chk("busy", busy, c <= W + G);
        chk("load_ready", load_ready, c == last);
      end
    end
    abort      = 1'b0;
    load_valid = 1'b0;
    if (abort_at == 0 || abort_at > W) begin
      exp_cap = lb ? word : pre;
      if (!lb) chk("chain", chain, word);
    end
    chk("cap_data", cap_data, exp_cap);
  endtask

  initial begin
    logic [W-1:0] w, p, b1, b2;
    int           ab;
    bit           lb, tg, seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_shift_out", shift_out, 0);
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_cap_data", cap_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("rel_load_ready", load_ready, 1);

    xfer(12'hA5C, 12'h000, 1'b1, 0, 1'b0);
    xfer(12'h000, 12'h3F0, 1'b0, 0, 1'b0);
    xfer(12'h6B2, 12'h000, 1'b1, 6, 1'b0);
    xfer(12'h9C3, 12'h5A5, 1'b0, 0, 1'b1);
    xfer(12'h1E7, 12'h000, 1'b1, W, 1'b0);

    // back-to-back on the GAP=0 instance with load_valid held high
    b1 = 12'hFFF;
    b2 = 12'h001;
    @(posedge clk); #1;
    lv0 = 1'b1;
    ld0 = b1;
    @(negedge clk);
    chk("b2b_rdy_pre", lr0, 1);
    for (int c = 1; c <= 2 * W + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) ld0 = b2;
      if (c == W + 2) lv0 = 1'b0;
      @(negedge clk);
      chk("b2b_cap_valid", cv0, c == W + 1 || c == 2 * W + 2);
      chk("b2b_load_ready", lr0, c == W + 1 || c == 2 * W + 2);
      chk("b2b_shift_en", se0, (c <= W) || (c >= W + 2 && c <= 2 * W + 1));
      if (c <= W)                 chk("b2b_shift_out", so0, b1[W-c]);
      else if (c == W + 1)        chk("b2b_shift_out", so0, 0);
      else if (c <= 2 * W + 1)    chk("b2b_shift_out", so0, b2[W-(c-W-1)]);
      if (c == W + 1)             chk("b2b_cap1", cd0, b1);
      if (c == 2 * W + 2)         chk("b2b_cap2", cd0, b2);
    end

    // async clear in the middle of SHIFT, then accept on the first edge after release
    @(posedge clk); #1;
    loopback   = 1'b1;
    load_valid = 1'b1;
    load_data  = 12'h5A3;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 clr = 1'b1;
    #1;
    chk("arst_shift_en", shift_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cap_data", cap_data, 0);
    chk("arst_shift_out", shift_out, 0);
    chk("arst_load_ready", load_ready, 0);
    #2 clr = 1'b0;
    exp_cap    = '0;
    load_valid = 1'b1;
    load_data  = 12'hC36;
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk("arst_accept_en", shift_en, 1);
    chk("arst_accept_bit", shift_out, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = load_ready;
    end
    chk("arst_done", seen, 1);
    exp_cap = 12'hC36;
    chk("arst_cap", cap_data, exp_cap);

    repeat (25) begin
      w  = W'($urandom);
      p  = W'($urandom);
      lb = 1'($urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + G)) : 0;
      xfer(w, p, lb, ab, tg);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
